uart_rx_ctrl: RTL



---
 rtl/uart_rx_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver for remote alarm commands.
//
// Decodes 8N1 frames from the asynchronous i_rx pin. Build with the
// UART_RX_PARITY_EN macro defined to receive 8E1/8O1 frames instead. A
// single-entry valid/ready buffer passes each accepted byte to the
// command decoder.
//
// Parameters:
//   CLK_FREQ    system clock in Hz
//   BAUD_RATE   line bit rate; CLK_FREQ/BAUD_RATE must be at least 4
//   PARITY_ODD  parity sense with UART_RX_PARITY_EN (0 = even, 1 = odd)
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_rx         serial line, idle high, asynchronous to i_clk
//   i_ready      consumer takes o_data when high together with o_valid
//   i_clr_err    synchronous clear of the sticky o_overrun flag
//   o_data       received byte (LSB first on the line)
//   o_valid      o_data holds an unconsumed byte
//   o_frame_err  1-cycle pulse: stop bit sampled low
//   o_parity_err 1-cycle pulse: parity mismatch (constant 0 without parity)
//   o_overrun    sticky: a byte completed while the buffer was full
//   o_busy       receiver FSM is not idle
module uart_rx_ctrl #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_ODD = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_ready,
  input  logic       i_clr_err,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Parity bit the transmitter should have sent for byte b.
  function automatic logic parity_expected(input logic [7:0] b);
    return (^b) ^ (PARITY_ODD != 0);
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_meta_p0;
  logic             rx_s;
  logic             parity_bad;

  // ---- stage p0/p1: two-flop synchronizer, reset to the idle-high level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_meta_p0 <= i_rx;
      rx_s       <= rx_meta_p0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;
  assign o_parity_err = parity_err_q;
`else
  assign parity_bad   = 1'b0;
  assign o_parity_err = 1'b0;
`endif

  // ---- frame FSM, delivery buffer and status flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (o_valid && i_ready) o_valid <= 1'b0;
      // A set later in this block overrides the clear.
      if (i_clr_err) o_overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state  <= S_START;
            cnt    <= '0;
            o_busy <= 1'b1;
          end
        end
        S_START: begin
          // Half a bit in: a line that went high again was a glitch.
          if (cnt == CNT_MID) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_END) begin
            shift[bit_idx] <= rx_s;
            cnt            <= '0;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_END) begin
            parity_bad <= (rx_s != parity_expected(shift));
            cnt        <= '0;
            state      <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          // Leaving at mid-stop leaves half a bit to catch the next start edge.
          if (cnt == CNT_END) begin
            cnt         <= '0;
            state       <= S_IDLE;
            o_busy      <= 1'b0;
            o_frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_bad;
`endif
            if (rx_s && !parity_bad) begin
              if (!o_valid || i_ready) begin
                o_data  <= shift;
                o_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
